// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// default geometry and address-split helpers.
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int DEF_LINES      = 64;
    localparam int DEF_LINE_WORDS = 4;

    // Address split for the default geometry
    localparam int OB    = 2 + $clog2(DEF_LINE_WORDS);
    localparam int IB    = $clog2(DEF_LINES);
    localparam int TAG_W = 32 - OB - IB;

    // Offset bits (byte offset inside a line) for a given words-per-line
    function automatic int ob_bits(input int line_words);
        return 2 + $clog2(line_words);
    endfunction

    // Index bits for a given line count
    function automatic int ib_bits(input int lines);
        return $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_ram.sv
// Generic storage array: asynchronous read, synchronous write gated by the
// clock enable. Used for both the tag array and the data array.
module icache_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_clk_ce,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are not reset, the valid bits guard every read
    always_ff @(posedge i_clk) begin
        if (i_clk_ce && i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Combinational lookup of the
// fetch PC, whole-line refill over a req/ack bus on a miss, full invalidate.
module icache
    import icache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clk_ce,
    input  logic [31:0] i_addr,
    output logic [31:0] o_data,
    output logic        o_hz_miss,
    input  logic        i_flush,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data
);

    localparam int L_OB = ob_bits(LINE_WORDS);
    localparam int L_IB = ib_bits(LINES);
    localparam int L_TW = 32 - L_OB - L_IB;
    localparam int WB   = $clog2(LINE_WORDS);
    localparam int DAW  = L_IB + WB;
    localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);

    // Lookup fields of the fetch PC; the byte offset is irrelevant
    logic [L_TW-1:0] a_tag;
    logic [L_IB-1:0] a_idx;
    logic [WB-1:0]   a_word;
    logic            unused_byte_bits;

    assign a_tag            = i_addr[31:L_OB+L_IB];
    assign a_idx            = i_addr[L_OB+L_IB-1:L_OB];
    assign a_word           = i_addr[L_OB-1:2];
    assign unused_byte_bits = ^i_addr[1:0];

    state_e          state_q, state_d;
    logic [WB-1:0]   cnt_q, cnt_d;
    logic [L_TW-1:0] b_tag_q, b_tag_d;
    logic [L_IB-1:0] b_idx_q, b_idx_d;
    logic            abort_q, abort_d;
    logic [LINES-1:0] valid_q, valid_d;

    logic            tag_we;
    logic            data_we;
    logic [L_TW-1:0] tag_rd;
    logic [31:0]     data_rd;
    logic            hit;

    icache_ram #(
        .DEPTH (LINES),
        .WIDTH (L_TW)
    ) u_tag_ram (
        .i_clk    (i_clk),
        .i_clk_ce (i_clk_ce),
        .i_we     (tag_we),
        .i_waddr  (b_idx_q),
        .i_wdata  (b_tag_q),
        .i_raddr  (a_idx),
        .o_rdata  (tag_rd)
    );

    icache_ram #(
        .DEPTH (LINES * LINE_WORDS),
        .WIDTH (32)
    ) u_data_ram (
        .i_clk    (i_clk),
        .i_clk_ce (i_clk_ce),
        .i_we     (data_we),
        .i_waddr  ({b_idx_q, cnt_q}),
        .i_wdata  (i_mem_data),
        .i_raddr  ({a_idx, a_word}),
        .o_rdata  (data_rd)
    );

    // Hits are only reported while idle, so a refill always stalls fetch
    assign hit        = (state_q == IDLE) && valid_q[a_idx] && (tag_rd == a_tag);
    assign o_hz_miss  = !hit;
    assign o_data     = hit ? data_rd : 32'h0;
    assign o_mem_req  = (state_q == FILL);
    assign o_mem_addr = (state_q == FILL) ? {b_tag_q, b_idx_q, cnt_q, 2'b00} : 32'h0;

    // Next-state logic: refill sequencing, valid-bit maintenance and flush
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_tag_d = b_tag_q;
        b_idx_d = b_idx_q;
        abort_d = abort_q;
        valid_d = valid_q;
        tag_we  = 1'b0;
        data_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_flush) begin
                    valid_d = '0;
                end else if (!hit) begin
                    state_d = FILL;
                    b_tag_d = a_tag;
                    b_idx_d = a_idx;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end
            end
            FILL: begin
                // The bus cannot abort, so a flush only poisons the line
                if (i_flush) begin
                    valid_d = '0;
                    abort_d = 1'b1;
                end
                if (i_mem_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + WB'(1);
                    if (cnt_q == LAST_BEAT) begin
                        tag_we           = 1'b1;
                        valid_d[b_idx_q] = !(abort_q || i_flush);
                        state_d          = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; every update is qualified by the clock enable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_tag_q <= '0;
            b_idx_q <= '0;
            abort_q <= 1'b0;
            valid_q <= '0;
        end else if (i_clk_ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_tag_q <= b_tag_d;
            b_idx_q <= b_idx_d;
            abort_q <= abort_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (default geometry: 64 lines x 4 words,
// index = addr[9:4], tag = addr[31:10]).
module tb_icache;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        miss;
    logic        flush;
    logic        req;
    logic [31:0] maddr;
    logic        ack;
    logic [31:0] mdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations recorded by the refill driver
    logic [31:0] beat_addr [4];
    int          fill_cycles;
    int          miss_cycles;
    int          stable_err;

    icache dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clk_ce   (ce),
        .i_addr     (addr),
        .o_data     (rdata),
        .o_hz_miss  (miss),
        .i_flush    (flush),
        .o_mem_req  (req),
        .o_mem_addr (maddr),
        .i_mem_ack  (ack),
        .i_mem_data (mdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-side driver for one refill. Entered at posedge+1 with the FSM in FILL.
    // Runs a fixed number of cycles (never waits on the DUT) and only records.
    task automatic run_refill(input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input int wait_cyc, input int flush_beat,
                              input int ce_beat, input int branch_beat,
                              input logic [31:0] branch_addr);
        logic [31:0] d [4];
        logic [31:0] first;
        logic        have_first;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        fill_cycles = 0;
        miss_cycles = 0;
        stable_err  = 0;
        for (int b = 0; b < 4; b++) begin
            have_first = 1'b0;
            first      = 32'h0;
            if (branch_beat == b) addr = branch_addr;
            for (int w = 0; w < wait_cyc; w++) begin
                @(negedge clk);
                if (!req) stable_err++;
                if (have_first && maddr != first) stable_err++;
                if (!have_first) begin first = maddr; have_first = 1'b1; end
                if (miss) miss_cycles++;
                fill_cycles++;
                @(posedge clk); #1;
            end
            if (ce_beat == b) begin
                ce = 1'b0; ack = 1'b1; mdata = d[b];
                for (int g = 0; g < 5; g++) begin
                    @(negedge clk);
                    if (!req) stable_err++;
                    if (have_first && maddr != first) stable_err++;
                    if (!have_first) begin first = maddr; have_first = 1'b1; end
                    if (miss) miss_cycles++;
                    fill_cycles++;
                    @(posedge clk); #1;
                end
                ce = 1'b1;
            end
            ack = 1'b1; mdata = d[b]; flush = (flush_beat == b);
            @(negedge clk);
            if (!req) stable_err++;
            if (have_first && maddr != first) stable_err++;
            if (miss) miss_cycles++;
            beat_addr[b] = maddr;
            fill_cycles++;
            @(posedge clk); #1;
            ack = 1'b0; mdata = 32'h0; flush = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ce = 1'b1; addr = 32'h0; flush = 1'b0; ack = 1'b0; mdata = 32'h0;
        repeat (2) @(negedge clk);
        n_checks++; if (miss !== 1'b1) begin n_fail++; $display("FAIL reset_miss: got %b expected 1", miss); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
        n_checks++; if (maddr !== 32'h0) begin n_fail++; $display("FAIL reset_maddr: got %h expected 00000000", maddr); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", rdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_basic_fill;
        // addr 0 misses; FSM is still IDLE this cycle
        @(negedge clk);
        n_checks++; if (miss !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL basic_miss_cycle: got miss=%b req=%b expected miss=1 req=0", miss, req); end
        @(posedge clk); #1;
        run_refill(32'h11, 32'h22, 32'h33, 32'h44, 0, -1, -1, -1, 32'h0);
        n_checks++; if (beat_addr[0] !== 32'h0 || beat_addr[3] !== 32'hC) begin n_fail++; $display("FAIL basic_beat_addr: got %h/%h expected 00000000/0000000c", beat_addr[0], beat_addr[3]); end
        n_checks++; if (1 + miss_cycles !== 5) begin n_fail++; $display("FAIL basic_stall: got %0d expected 5", 1 + miss_cycles); end
        @(negedge clk);
        n_checks++; if (miss !== 1'b0 || rdata !== 32'h11) begin n_fail++; $display("FAIL basic_hit0: got miss=%b data=%h expected miss=0 data=00000011", miss, rdata); end
        addr = 32'hC; #1;
        n_checks++; if (miss !== 1'b0 || rdata !== 32'h44) begin n_fail++; $display("FAIL basic_hitC: got miss=%b data=%h expected miss=0 data=00000044", miss, rdata); end
        $display("basic_fill: line 0x0 filled, stall=%0d", 1 + miss_cycles);
        @(posedge clk); #1;
    endtask

    task automatic test_conflict;
        addr = 32'h400;
        @(negedge clk);
        n_checks++; if (miss !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL conflict_miss: got miss=%b data=%h expected miss=1 data=00000000", miss, rdata); end
        @(posedge clk); #1;
        run_refill(32'hAA, 32'hBB, 32'hCC, 32'hDD, 0, -1, -1, -1, 32'h0);
        n_checks++; if (beat_addr[0] !== 32'h400) begin n_fail++; $display("FAIL conflict_beat_addr: got %h expected 00000400", beat_addr[0]); end
        @(negedge clk);
        n_checks++; if (miss !== 1'b0 || rdata !== 32'hAA) begin n_fail++; $display("FAIL conflict_hit: got miss=%b data=%h expected miss=0 data=000000aa", miss, rdata); end
        addr = 32'h0; #1;
        n_checks++; if (miss !== 1'b1) begin n_fail++; $display("FAIL conflict_evicted: got miss=%b expected 1", miss); end
        @(posedge clk); #1;
        run_refill(32'h11, 32'h22, 32'h33, 32'h44, 0, -1, -1, -1, 32'h0);
        $display("conflict: 0x400 evicted 0x0 and 0x0 refilled");
    endtask

    task automatic test_ack_stretch;
        addr = 32'h24;
        @(negedge clk);
        n_checks++; if (miss !== 1'b1) begin n_fail++; $display("FAIL stretch_miss: got %b expected 1", miss); end
        @(posedge clk); #1;
        run_refill(32'h2000, 32'h2004, 32'h2008, 32'h200C, 3, -1, -1, -1, 32'h0);
        n_checks++; if (stable_err !== 0) begin n_fail++; $display("FAIL stretch_stable: got %0d unstable samples expected 0", stable_err); end
        n_checks++; if (beat_addr[0] !== 32'h20 || beat_addr[1] !== 32'h24 || beat_addr[2] !== 32'h28 || beat_addr[3] !== 32'h2C) begin
            n_fail++; $display("FAIL stretch_addrs: got %h %h %h %h expected 00000020 00000024 00000028 0000002c", beat_addr[0], beat_addr[1], beat_addr[2], beat_addr[3]);
        end
        // 4 beats each preceded by 3 wait cycles keep the request up 16 cycles;
        // with the detection cycle the fetch stalls 17 cycles
        n_checks++; if (fill_cycles !== 16) begin n_fail++; $display("FAIL stretch_fill_cycles: got %0d expected 16", fill_cycles); end
        n_checks++; if (1 + miss_cycles !== 17) begin n_fail++; $display("FAIL stretch_stall: got %0d expected 17", 1 + miss_cycles); end
        @(negedge clk);
        n_checks++; if (miss !== 1'b0 || rdata !== 32'h2004) begin n_fail++; $display("FAIL stretch_hit: got miss=%b data=%h expected miss=0 data=00002004", miss, rdata); end
        $display("ack_stretch: fill_cycles=%0d stall=%0d", fill_cycles, 1 + miss_cycles);
        @(posedge clk); #1;
    endtask

    task automatic test_branch;
        addr = 32'h100;
        @(posedge clk); #1;
        run_refill(32'h1000, 32'h1004, 32'h1008, 32'h100C, 0, -1, -1, 1, 32'h840);
        n_checks++; if (beat_addr[3] !== 32'h10C) begin n_fail++; $display("FAIL branch_old_line: got %h expected 0000010c", beat_addr[3]); end
        @(negedge clk);
        n_checks++; if (miss !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL branch_new_miss: got miss=%b req=%b expected miss=1 req=0", miss, req); end
        @(posedge clk); #1;
        run_refill(32'h8400, 32'h8404, 32'h8408, 32'h840C, 0, -1, -1, -1, 32'h0);
        n_checks++; if (beat_addr[0] !== 32'h840) begin n_fail++; $display("FAIL branch_new_addr: got %h expected 00000840", beat_addr[0]); end
        @(negedge clk);
        n_checks++; if (miss !== 1'b0 || rdata !== 32'h8400) begin n_fail++; $display("FAIL branch_new_hit: got miss=%b data=%h expected miss=0 data=00008400", miss, rdata); end
        addr = 32'h108; #1;
        n_checks++; if (miss !== 1'b0 || rdata !== 32'h1008) begin n_fail++; $display("FAIL branch_old_hit: got miss=%b data=%h expected miss=0 data=00001008", miss, rdata); end
        $display("branch: 0x100 completed, 0x840 refilled");
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        // Flush during beat 2 of a refill
        addr = 32'h50;
        @(posedge clk); #1;
        run_refill(32'h500, 32'h504, 32'h508, 32'h50C, 0, 2, -1, -1, 32'h0);
        n_checks++; if (beat_addr[3] !== 32'h5C) begin n_fail++; $display("FAIL flush_mid_beats: got %h expected 0000005c", beat_addr[3]); end
        @(negedge clk);
        n_checks++; if (miss !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL flush_mid_invalid: got miss=%b req=%b expected miss=1 req=0", miss, req); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (req !== 1'b1 || maddr !== 32'h50) begin n_fail++; $display("FAIL flush_mid_rerefill: got req=%b addr=%h expected req=1 addr=00000050", req, maddr); end
        @(posedge clk); #1;
        run_refill(32'h600, 32'h604, 32'h608, 32'h60C, 0, -1, -1, -1, 32'h0);
        @(negedge clk);
        n_checks++; if (miss !== 1'b0 || rdata !== 32'h600) begin n_fail++; $display("FAIL flush_mid_hit: got miss=%b data=%h expected miss=0 data=00000600", miss, rdata); end
        // Other lines were invalidated by that flush
        addr = 32'h108; #1;
        n_checks++; if (miss !== 1'b1) begin n_fail++; $display("FAIL flush_mid_all: got miss=%b expected 1", miss); end
        addr = 32'h50;
        @(posedge clk); #1;
        // Flush coincident with the last ack
        addr = 32'h60;
        @(posedge clk); #1;
        run_refill(32'h7, 32'h7, 32'h7, 32'h7, 0, 3, -1, -1, 32'h0);
        @(negedge clk);
        n_checks++; if (miss !== 1'b1) begin n_fail++; $display("FAIL flush_last_ack: got miss=%b expected 1", miss); end
        @(posedge clk); #1;
        run_refill(32'h6000, 32'h6004, 32'h6008, 32'h600C, 0, -1, -1, -1, 32'h0);
        // Flush in IDLE on a missing address: no refill starts that cycle
        addr = 32'h90; flush = 1'b1;
        @(negedge clk);
        n_checks++; if (miss !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_cycle: got miss=%b req=%b expected miss=1 req=0", miss, req); end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_norefill: got req=%b expected 0", req); end
        @(posedge clk); #1;
        run_refill(32'h900, 32'h904, 32'h908, 32'h90C, 0, -1, -1, -1, 32'h0);
        addr = 32'h60; #1;
        n_checks++; if (miss !== 1'b1) begin n_fail++; $display("FAIL flush_idle_cleared: got miss=%b expected 1", miss); end
        addr = 32'h90; #1;
        n_checks++; if (miss !== 1'b0 || rdata !== 32'h900) begin n_fail++; $display("FAIL flush_idle_hit: got miss=%b data=%h expected miss=0 data=00000900", miss, rdata); end
        $display("flush: mid-fill, last-ack and idle flush scenarios done");
        @(posedge clk); #1;
    endtask

    task automatic test_clk_ce;
        addr = 32'h70;
        @(posedge clk); #1;
        run_refill(32'h700, 32'h704, 32'h708, 32'h70C, 0, -1, 1, -1, 32'h0);
        n_checks++; if (stable_err !== 0) begin n_fail++; $display("FAIL ce_stable: got %0d unstable samples expected 0", stable_err); end
        n_checks++; if (fill_cycles !== 9) begin n_fail++; $display("FAIL ce_fill_cycles: got %0d expected 9", fill_cycles); end
        n_checks++; if (beat_addr[1] !== 32'h74 || beat_addr[3] !== 32'h7C) begin n_fail++; $display("FAIL ce_beat_addr: got %h/%h expected 00000074/0000007c", beat_addr[1], beat_addr[3]); end
        @(negedge clk);
        n_checks++; if (miss !== 1'b0 || rdata !== 32'h700) begin n_fail++; $display("FAIL ce_hit0: got miss=%b data=%h expected miss=0 data=00000700", miss, rdata); end
        addr = 32'h78; #1;
        n_checks++; if (miss !== 1'b0 || rdata !== 32'h708) begin n_fail++; $display("FAIL ce_hit2: got miss=%b data=%h expected miss=0 data=00000708", miss, rdata); end
        $display("clk_ce: gated 5 cycles, fill_cycles=%0d", fill_cycles);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_fill;
        addr = 32'hA0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (req !== 1'b1 || maddr !== 32'hA0) begin n_fail++; $display("FAIL rstfill_req: got req=%b addr=%h expected req=1 addr=000000a0", req, maddr); end
        rst_n = 1'b0; #1;
        n_checks++; if (req !== 1'b0 || maddr !== 32'h0 || miss !== 1'b1) begin n_fail++; $display("FAIL rstfill_drop: got req=%b addr=%h miss=%b expected req=0 addr=00000000 miss=1", req, maddr, miss); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        addr = 32'h70; #1;
        n_checks++; if (miss !== 1'b1) begin n_fail++; $display("FAIL rstfill_valid_cleared: got miss=%b expected 1", miss); end
        addr = 32'hA0;
        @(posedge clk); #1;
        run_refill(32'hA00, 32'hA04, 32'hA08, 32'hA0C, 0, -1, -1, -1, 32'h0);
        @(negedge clk);
        n_checks++; if (miss !== 1'b0 || rdata !== 32'hA00) begin n_fail++; $display("FAIL rstfill_hit: got miss=%b data=%h expected miss=0 data=00000a00", miss, rdata); end
        $display("reset_mid_fill: request dropped, line refilled after reset");
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_basic_fill;
        test_conflict;
        test_ack_stretch;
        test_branch;
        test_flush;
        test_clk_ce;
        test_reset_mid_fill;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
